// File: rtl/lcd_char_sink_pkg.sv
// Shared types, constants and helpers for the lcd_char_sink character-LCD responder.
package lcd_char_sink_pkg;

  localparam logic [6:0] LCD_LINE1_BASE = 7'h40;
  localparam logic [7:0] LCD_SPACE      = 8'h20;
  localparam int         DDRAM_DEPTH    = 32;
  localparam int         DDRAM_AW       = 5;
  localparam int         LCD_DL_BIT     = 4;
  localparam int         LCD_ID_BIT     = 1;

  typedef enum logic {
    PH_HIGH = 1'b0,
    PH_LOW  = 1'b1
  } nib_phase_e;

  typedef enum logic [2:0] {
    CMD_NONE  = 3'd0,
    CMD_CLEAR = 3'd1,
    CMD_HOME  = 3'd2,
    CMD_ENTRY = 3'd3,
    CMD_CTRL  = 3'd4,
    CMD_FUNC  = 3'd5,
    CMD_CGRAM = 3'd6,
    CMD_DDRAM = 3'd7
  } cmd_e;

  // Instructions are identified by their most significant set bit.
  function automatic cmd_e decode_cmd(input logic [7:0] b);
    cmd_e c;
    if (b[7])              c = CMD_DDRAM;
    else if (b[6])         c = CMD_CGRAM;
    else if (b[5])         c = CMD_FUNC;
    else if (b[4] || b[3]) c = CMD_CTRL;
    else if (b[2])         c = CMD_ENTRY;
    else if (b[1])         c = CMD_HOME;
    else if (b[0])         c = CMD_CLEAR;
    else                   c = CMD_NONE;
    return c;
  endfunction

  // Address counter step; the two 16-character lines form one 32-entry ring.
  function automatic logic [6:0] ac_step(input logic [6:0] ac, input logic inc);
    logic [6:0] nxt;
    if (inc) begin
      if (ac == 7'h0F)      nxt = LCD_LINE1_BASE;
      else if (ac == 7'h4F) nxt = 7'h00;
      else                  nxt = ac + 7'd1;
    end else begin
      if (ac == 7'h00)                nxt = 7'h4F;
      else if (ac == LCD_LINE1_BASE)  nxt = 7'h0F;
      else                            nxt = ac - 7'd1;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/lcd_char_sink_ddram.sv
// 32x8 display RAM: one synchronous write port, one registered read port (read-before-write).
module lcd_char_sink_ddram
  import lcd_char_sink_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                we,
  input  logic [DDRAM_AW-1:0] waddr,
  input  logic [7:0]          wdata,
  input  logic [DDRAM_AW-1:0] raddr,
  output logic [7:0]          rdata
);

  logic [7:0] mem_q [DDRAM_DEPTH];
  logic [7:0] rdata_q, rdata_d;

  // Storage is deliberately not reset so a reset never wipes the screen image.
  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
  end

  always_comb rdata_d = mem_q[raddr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) rdata_q <= 8'h00;
    else     rdata_q <= rdata_d;
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/lcd_char_sink.sv
// HD44780-style responder on the 4-bit LCD bus with a 2x16 DDRAM mirror.
// Define LCD_BUSY_MODEL_EN for full busy timing; otherwise busy covers only the clear fill.
module lcd_char_sink
  import lcd_char_sink_pkg::*;
#(
  parameter int CMD_CYCLES   = 2000,
  parameter int CLEAR_CYCLES = 82000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       lcd_e,
  input  logic       lcd_rs,
  input  logic       lcd_rw,
  input  logic [3:0] lcd_dat,
  output logic [3:0] lcd_dat_o,
  output logic       lcd_dat_oe,
  input  logic [4:0] rd_addr,
  output logic [7:0] rd_char,
  output logic       byte_vld,
  output logic       byte_rs,
  output logic [7:0] byte_dat,
  output logic       busy,
  output logic       overrun
);

  logic [6:0] sync1_q, sync2_q;
  logic       e_prev_q;
  logic       e_s, rs_s, rw_s, xfer_s;
  logic [3:0] dat_s;

  nib_phase_e phase_q, phase_d;
  logic       mode4_q, mode4_d;
  logic [3:0] hi_nib_q, hi_nib_d;
  logic       byte_vld_q, byte_vld_d;
  logic       byte_rs_q, byte_rs_d;
  logic [7:0] byte_dat_q, byte_dat_d;
  logic [6:0] ac_q, ac_d;
  logic       id_q, id_d;
  logic       fill_q, fill_d;
  logic [4:0] fill_idx_q, fill_idx_d;
  logic       busy_q, busy_d;
  logic       overrun_q, overrun_d;
  logic [3:0] dat_o_q, dat_o_d;
  logic       oe_q, oe_d;
  logic       accept_s, we_s;
  logic [4:0] waddr_s;
  logic [7:0] wdata_s;
  cmd_e       cmd_s;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q  <= 7'd0;
      sync2_q  <= 7'd0;
      e_prev_q <= 1'b0;
    end else begin
      sync1_q  <= {lcd_e, lcd_rs, lcd_rw, lcd_dat};
      sync2_q  <= sync1_q;
      e_prev_q <= sync2_q[6];
    end
  end

  assign {e_s, rs_s, rw_s, dat_s} = sync2_q;
  assign xfer_s = e_prev_q & ~e_s;

  // Nibble assembly: 8-bit mode takes each write as a byte, 4-bit mode pairs HIGH/LOW.
  always_comb begin
    phase_d    = phase_q;
    hi_nib_d   = hi_nib_q;
    byte_vld_d = 1'b0;
    byte_rs_d  = byte_rs_q;
    byte_dat_d = byte_dat_q;
    if (xfer_s && rw_s) begin
      if (mode4_q) phase_d = (phase_q == PH_HIGH) ? PH_LOW : PH_HIGH;
      else         phase_d = PH_HIGH;
    end else if (xfer_s && !mode4_q) begin
      byte_vld_d = 1'b1;
      byte_rs_d  = rs_s;
      byte_dat_d = {dat_s, 4'h0};
    end else if (xfer_s) begin
      case (phase_q)
        PH_HIGH: begin
          hi_nib_d = dat_s;
          phase_d  = PH_LOW;
        end
        PH_LOW: begin
          byte_vld_d = 1'b1;
          byte_rs_d  = rs_s;
          byte_dat_d = {hi_nib_q, dat_s};
          phase_d    = PH_HIGH;
        end
        default: phase_d = PH_HIGH;
      endcase
    end else begin
      phase_d = phase_q;
    end
  end

  assign accept_s = byte_vld_q & ~busy_q;
  assign cmd_s    = decode_cmd(byte_dat_q);

  // Byte execution and the clear fill share the single DDRAM write port; fill implies busy.
  always_comb begin
    ac_d       = ac_q;
    id_d       = id_q;
    mode4_d    = mode4_q;
    fill_d     = fill_q;
    fill_idx_d = fill_idx_q;
    overrun_d  = overrun_q | (byte_vld_q & busy_q);
    we_s       = 1'b0;
    waddr_s    = {ac_q[6], ac_q[3:0]};
    wdata_s    = byte_dat_q;
    if (fill_q) begin
      we_s       = 1'b1;
      waddr_s    = fill_idx_q;
      wdata_s    = LCD_SPACE;
      fill_idx_d = fill_idx_q + 5'd1;
      if (fill_idx_q == 5'd31) begin
        fill_d = 1'b0;
        ac_d   = 7'h00;
        id_d   = 1'b1;
      end else begin
        fill_d = 1'b1;
      end
    end else if (accept_s && byte_rs_q) begin
      we_s = 1'b1;
      ac_d = ac_step(ac_q, id_q);
    end else if (accept_s) begin
      case (cmd_s)
        CMD_CLEAR: begin
          fill_d     = 1'b1;
          fill_idx_d = 5'd0;
        end
        CMD_HOME:  ac_d    = 7'h00;
        CMD_ENTRY: id_d    = byte_dat_q[LCD_ID_BIT];
        CMD_FUNC:  mode4_d = ~byte_dat_q[LCD_DL_BIT];
        CMD_DDRAM: begin
          if (byte_dat_q[6:4] == 3'b000 || byte_dat_q[6:4] == 3'b100) ac_d = byte_dat_q[6:0];
          else                                                       ac_d = ac_q;
        end
        default: ac_d = ac_q;
      endcase
    end else begin
      ac_d = ac_q;
    end
  end

  // Read responder: status nibble follows the current nibble phase; data reads return zero.
  always_comb begin
    oe_d    = e_s & rw_s;
    dat_o_d = 4'h0;
    if (e_s && rw_s && !rs_s) begin
      if (phase_q == PH_HIGH) dat_o_d = {busy_q, ac_q[6:4]};
      else                    dat_o_d = ac_q[3:0];
    end else begin
      dat_o_d = 4'h0;
    end
  end

`ifdef LCD_BUSY_MODEL_EN
  localparam int BUSY_MAX = (CLEAR_CYCLES > CMD_CYCLES) ? CLEAR_CYCLES : CMD_CYCLES;
  localparam int BUSY_W   = $clog2(BUSY_MAX + 1);

  logic [BUSY_W-1:0] busy_cnt_q, busy_cnt_d;

  // Every accepted byte reloads the countdown; clear gets the long delay.
  always_comb begin
    busy_cnt_d = busy_cnt_q;
    if (accept_s) begin
      if (!byte_rs_q && cmd_s == CMD_CLEAR) busy_cnt_d = BUSY_W'(CLEAR_CYCLES);
      else                                  busy_cnt_d = BUSY_W'(CMD_CYCLES);
    end else if (busy_cnt_q != '0) begin
      busy_cnt_d = busy_cnt_q - BUSY_W'(1);
    end else begin
      busy_cnt_d = busy_cnt_q;
    end
    busy_d = (busy_cnt_d != '0) | fill_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) busy_cnt_q <= '0;
    else     busy_cnt_q <= busy_cnt_d;
  end
`else
  logic unused_cfg_s;
  assign unused_cfg_s = ^{CMD_CYCLES, CLEAR_CYCLES};

  always_comb busy_d = fill_d;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase_q    <= PH_HIGH;
      mode4_q    <= 1'b0;
      hi_nib_q   <= 4'h0;
      byte_vld_q <= 1'b0;
      byte_rs_q  <= 1'b0;
      byte_dat_q <= 8'h00;
      ac_q       <= 7'h00;
      id_q       <= 1'b1;
      fill_q     <= 1'b0;
      fill_idx_q <= 5'd0;
      busy_q     <= 1'b0;
      overrun_q  <= 1'b0;
      dat_o_q    <= 4'h0;
      oe_q       <= 1'b0;
    end else begin
      phase_q    <= phase_d;
      mode4_q    <= mode4_d;
      hi_nib_q   <= hi_nib_d;
      byte_vld_q <= byte_vld_d;
      byte_rs_q  <= byte_rs_d;
      byte_dat_q <= byte_dat_d;
      ac_q       <= ac_d;
      id_q       <= id_d;
      fill_q     <= fill_d;
      fill_idx_q <= fill_idx_d;
      busy_q     <= busy_d;
      overrun_q  <= overrun_d;
      dat_o_q    <= dat_o_d;
      oe_q       <= oe_d;
    end
  end

  lcd_char_sink_ddram u_ddram (
    .clk   (clk),
    .rst   (rst),
    .we    (we_s),
    .waddr (waddr_s),
    .wdata (wdata_s),
    .raddr (rd_addr),
    .rdata (rd_char)
  );

  assign lcd_dat_o  = dat_o_q;
  assign lcd_dat_oe = oe_q;
  assign byte_vld   = byte_vld_q;
  assign byte_rs    = byte_rs_q;
  assign byte_dat   = byte_dat_q;
  assign busy       = busy_q;
  assign overrun    = overrun_q;

endmodule

// File: tb/tb_lcd_char_sink.sv
// Directed, table-driven bench for lcd_char_sink (honours LCD_BUSY_MODEL_EN for busy lengths).
module tb_lcd_char_sink;

  localparam int CMD_CYC = 40;
  localparam int CLR_CYC = 100;
`ifdef LCD_BUSY_MODEL_EN
  localparam int EXP_CLR_BUSY = CLR_CYC;
`else
  localparam int EXP_CLR_BUSY = 32;
`endif

  typedef struct {
    logic       rs;
    logic [7:0] b;
    logic       chk_mem;
    logic [4:0] addr;
    logic [7:0] exp_char;
    logic [6:0] exp_ac;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       lcd_e, lcd_rs, lcd_rw;
  logic [3:0] lcd_dat;
  logic [3:0] lcd_dat_o;
  logic       lcd_dat_oe;
  logic [4:0] rd_addr;
  logic [7:0] rd_char;
  logic       byte_vld, byte_rs, busy, overrun;
  logic [7:0] byte_dat;

  int         n_checks = 0;
  int         n_fail   = 0;
  logic [8:0] byte_log[$];
  int         busy_run = 0;
  int         last_busy_len = 0;
  vec_t       vecs[17];

  always #5 clk = ~clk;

  lcd_char_sink #(.CMD_CYCLES(CMD_CYC), .CLEAR_CYCLES(CLR_CYC)) dut (
    .clk(clk), .rst(rst), .lcd_e(lcd_e), .lcd_rs(lcd_rs), .lcd_rw(lcd_rw),
    .lcd_dat(lcd_dat), .lcd_dat_o(lcd_dat_o), .lcd_dat_oe(lcd_dat_oe),
    .rd_addr(rd_addr), .rd_char(rd_char), .byte_vld(byte_vld), .byte_rs(byte_rs),
    .byte_dat(byte_dat), .busy(busy), .overrun(overrun)
  );

  always @(negedge clk) begin
    if (byte_vld) byte_log.push_back({byte_rs, byte_dat});
    if (busy) busy_run++;
    else begin
      if (busy_run != 0) last_busy_len = busy_run;
      busy_run = 0;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic bus_cycle(input logic rs, input logic rw, input logic [3:0] nib,
                           output logic [3:0] rd_nib, output logic rd_oe);
    lcd_rs = rs; lcd_rw = rw; lcd_dat = nib; lcd_e = 1'b1;
    repeat (5) @(negedge clk);
    rd_nib = lcd_dat_o;
    rd_oe  = lcd_dat_oe;
    lcd_e  = 1'b0;
    repeat (6) @(negedge clk);
    lcd_rw = 1'b0;
  endtask

  task automatic write_nib(input logic rs, input logic [3:0] nib);
    logic [3:0] n;
    logic       o;
    bus_cycle(rs, 1'b0, nib, n, o);
  endtask

  task automatic write_byte(input logic rs, input logic [7:0] b);
    write_nib(rs, b[7:4]);
    write_nib(rs, b[3:0]);
  endtask

  task automatic read_nib(output logic [3:0] nib);
    logic o;
    bus_cycle(1'b0, 1'b1, 4'h0, nib, o);
    chk("read_oe", 32'(o), 32'd1);
  endtask

  task automatic read_status(output logic [7:0] s);
    logic [3:0] hi, lo;
    read_nib(hi);
    read_nib(lo);
    s = {hi, lo};
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk("wait_idle_timeout", 32'(busy), 32'd0);
    @(negedge clk);
  endtask

  task automatic expect_byte(input string name, input logic rs, input logic [7:0] b);
    if (byte_log.size() == 0) chk({name, "_missing"}, 32'd1, 32'd0);
    else chk(name, 32'(byte_log.pop_front()), 32'({rs, b}));
  endtask

  task automatic rd_mem(input logic [4:0] a, output logic [7:0] c);
    rd_addr = a;
    repeat (2) @(negedge clk);
    c = rd_char;
  endtask

  initial begin
    logic [7:0] st, c, ovr_cmd;
    logic [3:0] n;
    logic       o;

    vecs[0]  = '{1'b0, 8'h80, 1'b0, 5'd0,  8'h00, 7'h00};
    vecs[1]  = '{1'b1, 8'h48, 1'b1, 5'd0,  8'h48, 7'h01};
    vecs[2]  = '{1'b1, 8'h69, 1'b1, 5'd1,  8'h69, 7'h02};
    vecs[3]  = '{1'b0, 8'h8F, 1'b0, 5'd0,  8'h00, 7'h0F};
    vecs[4]  = '{1'b1, 8'h78, 1'b1, 5'd15, 8'h78, 7'h40};
    vecs[5]  = '{1'b0, 8'hCF, 1'b0, 5'd0,  8'h00, 7'h4F};
    vecs[6]  = '{1'b1, 8'h79, 1'b1, 5'd31, 8'h79, 7'h00};
    vecs[7]  = '{1'b0, 8'hC5, 1'b0, 5'd0,  8'h00, 7'h45};
    vecs[8]  = '{1'b0, 8'h90, 1'b0, 5'd0,  8'h00, 7'h45};
    vecs[9]  = '{1'b0, 8'h02, 1'b0, 5'd0,  8'h00, 7'h00};
    vecs[10] = '{1'b0, 8'hC0, 1'b0, 5'd0,  8'h00, 7'h40};
    vecs[11] = '{1'b0, 8'h04, 1'b0, 5'd0,  8'h00, 7'h40};
    vecs[12] = '{1'b1, 8'h42, 1'b1, 5'd16, 8'h42, 7'h0F};
    vecs[13] = '{1'b0, 8'h4A, 1'b0, 5'd0,  8'h00, 7'h0F};
    vecs[14] = '{1'b0, 8'h06, 1'b0, 5'd0,  8'h00, 7'h0F};
    vecs[15] = '{1'b0, 8'h0C, 1'b0, 5'd0,  8'h00, 7'h0F};
    vecs[16] = '{1'b1, 8'h43, 1'b1, 5'd15, 8'h43, 7'h40};

    rst = 1'b1; lcd_e = 1'b0; lcd_rs = 1'b0; lcd_rw = 1'b0; lcd_dat = 4'h0; rd_addr = 5'd0;
    repeat (3) @(negedge clk);
    chk("rst_busy",     32'(busy),       32'd0);
    chk("rst_overrun",  32'(overrun),    32'd0);
    chk("rst_byte_vld", 32'(byte_vld),   32'd0);
    chk("rst_oe",       32'(lcd_dat_oe), 32'd0);
    chk("rst_dat_o",    32'(lcd_dat_o),  32'd0);
    chk("rst_rd_char",  32'(rd_char),    32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Power-on init: three 8-bit function sets, switch to 4-bit, then 0x28.
    for (int i = 0; i < 3; i++) begin
      write_nib(1'b0, 4'h3);
      wait_idle();
    end
    write_nib(1'b0, 4'h2);
    wait_idle();
    write_byte(1'b0, 8'h28);
    wait_idle();
    expect_byte("init_b0", 1'b0, 8'h30);
    expect_byte("init_b1", 1'b0, 8'h30);
    expect_byte("init_b2", 1'b0, 8'h30);
    expect_byte("init_b3", 1'b0, 8'h20);
    expect_byte("init_b4", 1'b0, 8'h28);
`ifdef LCD_BUSY_MODEL_EN
    chk("cmd_busy_len", 32'(last_busy_len), 32'(CMD_CYC));
`endif

    for (int i = 0; i < 17; i++) begin
      write_byte(vecs[i].rs, vecs[i].b);
      wait_idle();
      expect_byte($sformatf("tbl%0d_byte", i), vecs[i].rs, vecs[i].b);
      if (vecs[i].chk_mem) begin
        rd_mem(vecs[i].addr, c);
        chk($sformatf("tbl%0d_char", i), 32'(c), 32'(vecs[i].exp_char));
      end
      read_status(st);
      chk($sformatf("tbl%0d_ac", i), 32'(st), 32'({1'b0, vecs[i].exp_ac}));
    end
    rd_mem(5'd0, c);
    chk("mem0_still_H", 32'(c), 32'h48);

    // Line 1 fill: 16 bytes from 0x40 land in entries 16..31 and wrap AC to 0x00.
    write_byte(1'b0, 8'hC0);
    wait_idle();
    for (int i = 0; i < 16; i++) begin
      write_byte(1'b1, 8'(8'h61 + i));
      wait_idle();
    end
    for (int i = 0; i < 16; i++) begin
      rd_mem(5'(16 + i), c);
      chk($sformatf("line1_%0d", i), 32'(c), 32'(8'h61 + i));
    end
    read_status(st);
    chk("line1_wrap_ac", 32'(st), 32'h00);
    byte_log.delete();

    // Data-register reads return zero.
    for (int i = 0; i < 2; i++) begin
      bus_cycle(1'b1, 1'b1, 4'h0, n, o);
      chk("rs1_read", 32'(n), 32'h0);
    end

    // Clear display: busy visible in the status nibble during the fill.
    chk("pre_clear_overrun", 32'(overrun), 32'd0);
    write_byte(1'b0, 8'h01);
    read_status(st);
    chk("clear_busy_hi", 32'(st[7:4]), 32'h8);
    chk("clear_busy_lo", 32'(st[3:0]), 32'h0);
    expect_byte("clear_byte", 1'b0, 8'h01);
    wait_idle();
    chk("clear_busy_len", 32'(last_busy_len), 32'(EXP_CLR_BUSY));
    read_status(st);
    chk("after_clear_status", 32'(st), 32'h00);
    for (int i = 0; i < 32; i++) begin
      rd_mem(5'(i), c);
      chk($sformatf("clear_%0d", i), 32'(c), 32'h20);
    end
    chk("clear_no_overrun", 32'(overrun), 32'd0);

    // Byte while busy: still reported, but discarded and flagged as overrun.
`ifdef LCD_BUSY_MODEL_EN
    ovr_cmd = 8'h0C;
`else
    ovr_cmd = 8'h01;
`endif
    write_byte(1'b0, ovr_cmd);
    write_byte(1'b1, 8'h55);
    wait_idle();
    chk("overrun_set", 32'(overrun), 32'd1);
    expect_byte("ovr_cmd_byte", 1'b0, ovr_cmd);
    expect_byte("ovr_data_byte", 1'b1, 8'h55);
    rd_mem(5'd0, c);
    chk("ovr_mem0", 32'(c), 32'h20);
    read_status(st);
    chk("ovr_ac", 32'(st), 32'h00);

    // Decrement mode wraps 0x00 to 0x4F; then reset in the middle of a clear.
    write_byte(1'b0, 8'h04); wait_idle();
    write_byte(1'b0, 8'h80); wait_idle();
    write_byte(1'b1, 8'h41); wait_idle();
    read_status(st);
    chk("dec_wrap_ac", 32'(st), 32'h4F);
    write_byte(1'b1, 8'h5A); wait_idle();
    read_status(st);
    chk("dec_ac", 32'(st), 32'h4E);
    rd_mem(5'd31, c);
    chk("dec_mem31", 32'(c), 32'h5A);
    write_byte(1'b0, 8'h01);
    repeat (5) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("midrst_busy",     32'(busy),       32'd0);
    chk("midrst_overrun",  32'(overrun),    32'd0);
    chk("midrst_byte_vld", 32'(byte_vld),   32'd0);
    chk("midrst_oe",       32'(lcd_dat_oe), 32'd0);
    chk("midrst_dat_o",    32'(lcd_dat_o),  32'd0);
    chk("midrst_rd_char",  32'(rd_char),    32'd0);
    rst = 1'b0;
    @(negedge clk);
    rd_mem(5'd0, c);
    chk("midrst_mem0_filled", 32'(c), 32'h20);
    rd_mem(5'd31, c);
    chk("midrst_mem31_kept", 32'(c), 32'h5A);
    read_nib(n);
    chk("midrst_status8", 32'(n), 32'h0);
    byte_log.delete();
    write_nib(1'b0, 4'h8);
    wait_idle();
    expect_byte("midrst_8bit_mode", 1'b0, 8'h80);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
